operand_fetch: RTL
==================

// Module: operand_fetch
// PURPOSE
//  Decode/operand-fetch stage directly upstream of the 32x32 register file.
//  - Accepts fetched instructions and drives the regfile read addresses.
//  - Captures operands, with bypass from the writeback bus.
//  - Tracks in-flight destination registers in a scoreboard; stalls on RAW hazards.
//  - Presents a registered, valid/ready operand bundle to the execute stage.
// PARAMETERS
//  XLEN      32  datapath / instruction width
//  NREG      32  architectural registers (address width = log2(NREG) = 5)
//  LINK_REG  31  destination written by JAL
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     synchronous, active-high reset
//  in_valid   in   1     fetch offers an instruction
//  in_ready   out  1     stage accepts this cycle (comb)
//  in_instr   in   32    instruction word
//  in_pc      in   32    instruction address
//  rf_addr_a  out  5     regfile read port A = in_instr[25:21] (comb)
//  rf_addr_b  out  5     regfile read port B = in_instr[20:16] (comb)
//  rf_data_a  in   32    regfile read data A, combinational same cycle
//  rf_data_b  in   32    regfile read data B, combinational same cycle
//  wb_valid   in   1     writeback retiring this cycle (also drives regfile write_enable)
//  wb_addr    in   5     writeback register
//  wb_data    in   32    writeback value
//  out_valid  out  1     bundle valid to execute
//  out_ready  in   1     execute accepts
//  out_pc     out  32    registered PC
//  out_instr  out  32    registered instruction
//  out_opa    out  32    registered rs operand
//  out_opb    out  32    registered rt operand
//  out_dst    out  5     registered destination (0 if none)
//  out_wen    out  1     instruction writes a register
// BEHAVIOUR
//  Decode on op = instr[31:26]:
//  - R-type (op 0): src rs, rt; dst rd.
//  - ALU-imm (op[5:3] = 3'b001) and LW (6'h23): src rs; dst rt.
//  - SW (6'h2B), BEQ (6'h04), BNE (6'h05): src rs, rt; no write.
//  - J (6'h02): no src; no write.
//  - JAL (6'h03): no src; dst LINK_REG.
//  - Unknown op: treated as no-src, no-write.
//  - Destination r0 => out_wen = 0, out_dst = 0.
//  Operand select, per port, priority order:
//  - addr == 0 -> 0 (r0 forced to zero regardless of regfile content).
//  - wb_valid && wb_addr == addr -> wb_data (bypass).
//  - otherwise rf_data.
//  Scoreboard: busy[NREG], one bit per register; busy[0] never set.
//  - hazard = a used source s != 0 with busy[s] && !(wb_valid && wb_addr == s).
//  - in_ready = !hazard && (!out_valid || out_ready). fire = in_valid && in_ready.
//  - On fire with wen: busy[dst] <= 1. On wb_valid: busy[wb_addr] <= 0.
//  - Same register set and cleared in one cycle: set wins.
//  - Writeback to a non-busy register: clear is a no-op, no error.
//  - Only one in-flight writer per register: a WAW (dst already busy) also stalls.
//  Pipeline register, latency 1 cycle fire -> out_valid:
//  - On fire: load all out_* and set out_valid.
//  - Else if out_ready: out_valid <= 0.
//  - out_* hold while out_valid && !out_ready.
//  Reset (sync): out_valid = 0; out_pc, out_instr, out_opa, out_opb, out_dst, out_wen = 0;
//  busy = all 0. An instruction held at reset is dropped; execute must not retire
//  a writeback in the reset cycle.
//  rf_addr_* are driven from in_instr even when in_valid = 0.
// STRUCTURE
//  Package llama_pkg:
//  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL).
//  - instruction field bit ranges.
//  - XLEN and register address width.
//  Sub-module hazard_scoreboard:
//  - holds busy bits.
//  - inputs: src/use flags, set port, clear port.
//  - outputs: hazard.
//  Decode and operand muxing stay in operand_fetch.
// TESTING
//  1. Reset: rst high 1 cycle, in_valid = 1 -> out_valid = 0, busy all 0, in_ready = 1 next cycle.
//  2. ADD r3,r1,r2 with regfile r1 = 5, r2 = 7 -> one cycle later out_opa = 5, out_opb = 7, out_dst = 3, out_wen = 1.
//  3. ADD r3 then SUB r4,r3,r1 back to back, no writeback -> in_ready = 0 until wb_valid
//     with wb_addr = 3, wb_data = 0x1234; same cycle fires, out_opa = 0x1234.
//  4. out_ready = 0 for 3 cycles with out_valid = 1 -> out_* stable, in_ready = 0; on release the next instruction issues.
//  5. ADDI r0,r0,9 then ADD r5,r0,r0 -> out_wen = 0 for the first, operands 0, no stall on the second.
//  6. JAL -> out_dst = 31, busy[31] set. SW r31,0(r2) then stalls until wb_addr = 31,
//     and the same-cycle set/clear case leaves busy set.

Source files
------------

// File: rtl/llama_pkg.sv
// Shared ISA constants and helpers for the decode/operand-fetch stage.
// Opcodes, instruction field ranges and the per-port operand select.
package llama_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned REG_AW = $clog2(NREG);

  localparam logic [REG_AW-1:0] LINK_REG = 5'd31;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_MSB = 25;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_MSB = 20;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_MSB = 15;
  localparam int unsigned RD_LSB = 11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // ALU-immediate group is identified by the top three opcode bits.
  localparam logic [2:0] OP_ALUI_HI = 3'b001;

  // r0 reads as zero, then the writeback bus, then the regfile.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [REG_AW-1:0] addr,
    input logic [XLEN-1:0]   rf_data,
    input logic              wb_valid,
    input logic [REG_AW-1:0] wb_addr,
    input logic [XLEN-1:0]   wb_data
  );
    if (addr == '0) return '0;
    if (wb_valid && (wb_addr == addr)) return wb_data;
    return rf_data;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy bit per architectural register; flags RAW and WAW hazards for the
// instruction currently offered, taking a same-cycle writeback into account.
module hazard_scoreboard
  import llama_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] src_a,
  input  logic              use_a,
  input  logic [REG_AW-1:0] src_b,
  input  logic              use_b,
  input  logic [REG_AW-1:0] dst,
  input  logic              use_dst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_addr,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_addr,
  output logic              hazard
);

  logic [NREG-1:0] busy_q, busy_d;
  logic            pend_a, pend_b, pend_d;

  // A register retiring this cycle is no longer pending.
  assign pend_a = use_a && (src_a != '0) && busy_q[src_a] && !(clr_en && (clr_addr == src_a));
  assign pend_b = use_b && (src_b != '0) && busy_q[src_b] && !(clr_en && (clr_addr == src_b));
  assign pend_d = use_dst && (dst != '0) && busy_q[dst] && !(clr_en && (clr_addr == dst));
  assign hazard = pend_a || pend_b || pend_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes sources and destination, reads the
// regfile with writeback bypass, stalls on scoreboard hazards, registers a bundle.
module operand_fetch
  import llama_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rf_addr_a,
  output logic [REG_AW-1:0] rf_addr_b,
  input  logic [XLEN-1:0]   rf_data_a,
  input  logic [XLEN-1:0]   rf_data_b,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_instr,
  output logic [XLEN-1:0]   out_opa,
  output logic [XLEN-1:0]   out_opb,
  output logic [REG_AW-1:0] out_dst,
  output logic              out_wen
);

  logic [5:0]        op;
  logic [REG_AW-1:0] rs, rt, rd;
  logic              use_a, use_b;
  logic [REG_AW-1:0] dst;
  logic              wen;
  logic              hazard, fire;

  logic              valid_q;
  logic [XLEN-1:0]   pc_q, instr_q, opa_q, opb_q;
  logic [REG_AW-1:0] dst_q;
  logic              wen_q;

  assign op = in_instr[OP_MSB:OP_LSB];
  assign rs = in_instr[RS_MSB:RS_LSB];
  assign rt = in_instr[RT_MSB:RT_LSB];
  assign rd = in_instr[RD_MSB:RD_LSB];

  assign rf_addr_a = rs;
  assign rf_addr_b = rt;

  always_comb begin
    use_a = 1'b0;
    use_b = 1'b0;
    dst   = '0;
    case (op)
      OP_RTYPE: begin
        use_a = 1'b1;
        use_b = 1'b1;
        dst   = rd;
      end
      OP_LW: begin
        use_a = 1'b1;
        dst   = rt;
      end
      OP_SW, OP_BEQ, OP_BNE: begin
        use_a = 1'b1;
        use_b = 1'b1;
      end
      OP_JAL:  dst = LINK_REG;
      OP_J:    dst = '0;
      default: begin
        if (op[5:3] == OP_ALUI_HI) begin
          use_a = 1'b1;
          dst   = rt;
        end
      end
    endcase
  end

  // Writes to r0 are discarded, so they never claim the scoreboard.
  assign wen = (dst != '0);

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .src_a    (rs),
    .use_a    (use_a),
    .src_b    (rt),
    .use_b    (use_b),
    .dst      (dst),
    .use_dst  (wen),
    .set_en   (fire && wen),
    .set_addr (dst),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .hazard   (hazard)
  );

  assign in_ready = !hazard && (!valid_q || out_ready);
  assign fire     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
      pc_q    <= in_pc;
      instr_q <= in_instr;
      opa_q   <= sel_operand(rs, rf_data_a, wb_valid, wb_addr, wb_data);
      opb_q   <= sel_operand(rt, rf_data_b, wb_valid, wb_addr, wb_data);
      dst_q   <= dst;
      wen_q   <= wen;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;
  assign out_opa   = opa_q;
  assign out_opb   = opb_q;
  assign out_dst   = dst_q;
  assign out_wen   = wen_q;

endmodule
